instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
- Requester side of the instruction memory interface: owns the program counter, drives the byte address to the instruction memory, and captures the returned 32-bit word into an IF/ID register for the decoder.
- Handles sequential fetch, branch/jump redirect with flush, decode stall, and halt detection.
- Sits between the instruction memory (combinational read: word at address pc is available the same cycle) and the decode stage.

Parameters:
- ADDR_WIDTH, 8, byte-address width of the instruction memory (256 bytes).
- DATA_WIDTH, 32, instruction width.
- RESET_PC, 0, PC value loaded on reset (word aligned).
- HALT_WORD, 32'hFFFFFFFF, instruction encoding that stops fetch.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-low (rst=0 resets).
- stall  input  1  decode not ready; hold PC and IF/ID.
- redirect  input  1  taken branch or jump this cycle.
- redirect_target  input  ADDR_WIDTH  new PC on redirect.
- imem_instruct  input  DATA_WIDTH  word returned by instruction memory for imem_pc.
- imem_pc  output  ADDR_WIDTH  fetch address to instruction memory (= PC register).
- if_valid  output  1  IF/ID holds a valid instruction.
- if_instruct  output  DATA_WIDTH  IF/ID instruction.
- if_pc  output  ADDR_WIDTH  address of if_instruct.
- if_pc_plus4  output  ADDR_WIDTH  if_pc+4, modulo 2^ADDR_WIDTH.
- halted  output  1  fetch stopped on HALT_WORD.
- misalign_err  output  1  one-cycle pulse: redirect target had nonzero bits [1:0].
- fetch_count  output  16  number of instructions delivered (if_valid rising into a new word), saturating at 16'hFFFF.

Behaviour:
- Reset (rst=0, async): PC=RESET_PC; state=BOOT; if_valid=0; if_instruct=0; if_pc=0; if_pc_plus4=0; halted=0; misalign_err=0; fetch_count=0.
- State machine: BOOT -> RUN -> HALT. No other transitions. HALT is left only by reset.
- BOOT (exactly one cycle after rst deasserts): no capture, PC unchanged, if_valid=0, next state RUN. Redirect and stall are ignored in BOOT.
- RUN, priority per cycle: redirect > stall > sequential.
- Redirect (regardless of stall):
  - PC <= {redirect_target[ADDR_WIDTH-1:2], 2'b00}.
  - if_valid <= 0 (flushes the wrong-path word at imem_pc).
  - misalign_err <= (redirect_target[1:0] != 0) for one cycle.
  - Halt detection is suppressed that cycle.
- Stall, no redirect: PC, IF/ID registers and fetch_count hold.
- Sequential (no stall, no redirect):
  - If imem_instruct == HALT_WORD: if_valid <= 0, halted <= 1, state <= HALT, PC holds.
  - Otherwise: if_instruct <= imem_instruct; if_pc <= PC; if_pc_plus4 <= PC+4; if_valid <= 1; PC <= PC+4; fetch_count increments unless already 16'hFFFF.
- Latency: a word appears on if_instruct one clock after its address is on imem_pc; throughput is one instruction per cycle.
- Wrap-around: PC+4 is modulo 2^ADDR_WIDTH, so 8'hFC -> 8'h00 with no error.
- HALT: PC, if_* and fetch_count frozen; if_valid=0; halted=1; stall and redirect ignored.
- misalign_err is 0 in every cycle without a misaligned redirect.
- Reset mid-operation: all outputs return to reset values immediately, without waiting for a clock edge.

Test Plan:
- Reset then sequential run: mem[0..11] = words 0x11111111, 0x22222222, 0x33333333 -> BOOT cycle with if_valid=0, then imem_pc 0,4,8; if_instruct 0x11111111 at if_pc=0, then 0x22222222 at if_pc=4, 0x33333333 at if_pc=8; fetch_count=3.
- Stall for 3 cycles with PC=8 -> imem_pc stays 8, if_instruct stays 0x22222222, if_valid stays 1; fetch resumes on the cycle after stall drops.
- Redirect to 0x40 asserted together with stall -> next cycle imem_pc=0x40, if_valid=0; the following cycle if_pc=0x40; misalign_err=0.
- Redirect to 0x43 -> imem_pc=0x40, misalign_err pulses high for exactly one cycle.
- PC at 0xFC holding a non-halt word -> if_pc=0xFC, if_pc_plus4=0x00, imem_pc wraps to 0x00.
- mem[0x10]=0xFFFFFFFF -> halted=1, if_valid=0, imem_pc frozen at 0x10 while redirects are applied; rst low mid-run clears halted and returns imem_pc to 0 asynchronously.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the combinational instruction
// memory and registers the returned word into IF/ID for the decoder.
module instruction_fetch_unit #(
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter logic [DATA_WIDTH-1:0] HALT_WORD  = 32'hFFFF_FFFF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_target,
  input  logic [DATA_WIDTH-1:0] imem_instruct,
  output logic [ADDR_WIDTH-1:0] imem_pc,
  output logic                  if_valid,
  output logic [DATA_WIDTH-1:0] if_instruct,
  output logic [ADDR_WIDTH-1:0] if_pc,
  output logic [ADDR_WIDTH-1:0] if_pc_plus4,
  output logic                  halted,
  output logic                  misalign_err,
  output logic [15:0]           fetch_count
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   pc;
  logic [ADDR_WIDTH-1:0]   pc_next_seq;

  assign imem_pc     = pc;
  assign pc_next_seq = pc + PC_STEP;

  // Redirect outranks stall; halt detection only happens on a plain sequential fetch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= BOOT;
      pc           <= RESET_PC;
      if_valid     <= 1'b0;
      if_instruct  <= '0;
      if_pc        <= '0;
      if_pc_plus4  <= '0;
      halted       <= 1'b0;
      misalign_err <= 1'b0;
      fetch_count  <= '0;
    end else begin
      misalign_err <= 1'b0;
      case (state)
        BOOT: begin
          if_valid <= 1'b0;
          state    <= RUN;
        end
        RUN: begin
          if (redirect) begin
            pc           <= {redirect_target[ADDR_WIDTH-1:2], 2'b00};
            if_valid     <= 1'b0;
            misalign_err <= (redirect_target[1:0] != 2'b00);
          end else if (!stall) begin
            if (imem_instruct == HALT_WORD) begin
              if_valid <= 1'b0;
              halted   <= 1'b1;
              state    <= HALT;
            end else begin
              if_instruct <= imem_instruct;
              if_pc       <= pc;
              if_pc_plus4 <= pc_next_seq;
              if_valid    <= 1'b1;
              pc          <= pc_next_seq;
              if (fetch_count != 16'hFFFF) begin
                fetch_count <= fetch_count + 16'd1;
              end
            end
          end
        end
        HALT: begin
          if_valid <= 1'b0;
          halted   <= 1'b1;
        end
        default: begin
          state    <= BOOT;
          if_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: drives a small word memory model and
// checks hand-computed fetch, stall, redirect, wrap, halt and reset behaviour.
module tb_instruction_fetch_unit;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [7:0]  redirect_target;
  logic [31:0] imem_instruct;
  logic [7:0]  imem_pc;
  logic        if_valid;
  logic [31:0] if_instruct;
  logic [7:0]  if_pc;
  logic [7:0]  if_pc_plus4;
  logic        halted;
  logic        misalign_err;
  logic [15:0] fetch_count;

  logic [31:0] mem [0:63];
  int          pass_count = 0;
  int          check_count = 0;

  instruction_fetch_unit dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .imem_instruct   (imem_instruct),
    .imem_pc         (imem_pc),
    .if_valid        (if_valid),
    .if_instruct     (if_instruct),
    .if_pc           (if_pc),
    .if_pc_plus4     (if_pc_plus4),
    .halted          (halted),
    .misalign_err    (misalign_err),
    .fetch_count     (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign imem_instruct = mem[imem_pc[7:2]];

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    check_count++;
    assert (observed === expected) pass_count++;
    else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
  endtask

  task automatic apply_stimulus(input logic s, input logic r, input logic [7:0] tgt);
    stall           = s;
    redirect        = r;
    redirect_target = tgt;
  endtask

  // Advance one clock and land on the following falling edge for sampling.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0000_0013;
    mem[0]  = 32'h1111_1111;
    mem[1]  = 32'h2222_2222;
    mem[2]  = 32'h3333_3333;
    mem[4]  = 32'hFFFF_FFFF;
    mem[16] = 32'hAAAA_0040;
    mem[63] = 32'hBBBB_00FC;

    rst = 1'b0;
    apply_stimulus(1'b0, 1'b0, 8'h00);
    step();
    check_output("reset_imem_pc", 32'(imem_pc), 32'h00);
    check_output("reset_if_valid", 32'(if_valid), 32'h0);
    check_output("reset_if_instruct", if_instruct, 32'h0);
    check_output("reset_fetch_count", 32'(fetch_count), 32'h0);
    check_output("reset_halted", 32'(halted), 32'h0);

    rst = 1'b1;
    step();
    check_output("boot_if_valid", 32'(if_valid), 32'h0);
    check_output("boot_imem_pc", 32'(imem_pc), 32'h00);

    step();
    check_output("seq0_if_instruct", if_instruct, 32'h1111_1111);
    check_output("seq0_if_pc", 32'(if_pc), 32'h00);
    check_output("seq0_if_pc_plus4", 32'(if_pc_plus4), 32'h04);
    check_output("seq0_imem_pc", 32'(imem_pc), 32'h04);
    check_output("seq0_if_valid", 32'(if_valid), 32'h1);

    step();
    check_output("seq1_if_instruct", if_instruct, 32'h2222_2222);
    check_output("seq1_if_pc", 32'(if_pc), 32'h04);
    check_output("seq1_imem_pc", 32'(imem_pc), 32'h08);

    apply_stimulus(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      step();
      check_output("stall_imem_pc", 32'(imem_pc), 32'h08);
      check_output("stall_if_instruct", if_instruct, 32'h2222_2222);
      check_output("stall_if_valid", 32'(if_valid), 32'h1);
      check_output("stall_fetch_count", 32'(fetch_count), 32'd2);
    end

    apply_stimulus(1'b0, 1'b0, 8'h00);
    step();
    check_output("seq2_if_instruct", if_instruct, 32'h3333_3333);
    check_output("seq2_if_pc", 32'(if_pc), 32'h08);
    check_output("seq2_fetch_count", 32'(fetch_count), 32'd3);
    check_output("seq2_imem_pc", 32'(imem_pc), 32'h0C);

    apply_stimulus(1'b1, 1'b1, 8'h40);
    step();
    check_output("redir40_imem_pc", 32'(imem_pc), 32'h40);
    check_output("redir40_if_valid", 32'(if_valid), 32'h0);
    check_output("redir40_misalign", 32'(misalign_err), 32'h0);
    check_output("redir40_fetch_count", 32'(fetch_count), 32'd3);

    apply_stimulus(1'b0, 1'b0, 8'h00);
    step();
    check_output("tgt40_if_pc", 32'(if_pc), 32'h40);
    check_output("tgt40_if_instruct", if_instruct, 32'hAAAA_0040);
    check_output("tgt40_fetch_count", 32'(fetch_count), 32'd4);

    apply_stimulus(1'b0, 1'b1, 8'h43);
    step();
    check_output("redir43_imem_pc", 32'(imem_pc), 32'h40);
    check_output("redir43_misalign", 32'(misalign_err), 32'h1);
    check_output("redir43_if_valid", 32'(if_valid), 32'h0);

    apply_stimulus(1'b0, 1'b0, 8'h00);
    step();
    check_output("after43_misalign", 32'(misalign_err), 32'h0);
    check_output("after43_if_pc", 32'(if_pc), 32'h40);
    check_output("after43_fetch_count", 32'(fetch_count), 32'd5);

    apply_stimulus(1'b0, 1'b1, 8'hFC);
    step();
    check_output("redirFC_imem_pc", 32'(imem_pc), 32'hFC);
    apply_stimulus(1'b0, 1'b0, 8'h00);
    step();
    check_output("wrap_if_pc", 32'(if_pc), 32'hFC);
    check_output("wrap_if_pc_plus4", 32'(if_pc_plus4), 32'h00);
    check_output("wrap_imem_pc", 32'(imem_pc), 32'h00);
    check_output("wrap_if_instruct", if_instruct, 32'hBBBB_00FC);
    check_output("wrap_misalign", 32'(misalign_err), 32'h0);

    apply_stimulus(1'b0, 1'b1, 8'h10);
    step();
    check_output("redir10_imem_pc", 32'(imem_pc), 32'h10);
    apply_stimulus(1'b0, 1'b0, 8'h00);
    step();
    check_output("halt_halted", 32'(halted), 32'h1);
    check_output("halt_if_valid", 32'(if_valid), 32'h0);
    check_output("halt_imem_pc", 32'(imem_pc), 32'h10);
    check_output("halt_fetch_count", 32'(fetch_count), 32'd6);
    check_output("halt_if_pc", 32'(if_pc), 32'hFC);

    apply_stimulus(1'b1, 1'b1, 8'h83);
    step();
    step();
    check_output("halt_redir_imem_pc", 32'(imem_pc), 32'h10);
    check_output("halt_redir_misalign", 32'(misalign_err), 32'h0);
    check_output("halt_redir_halted", 32'(halted), 32'h1);
    check_output("halt_redir_if_instruct", if_instruct, 32'hBBBB_00FC);

    apply_stimulus(1'b0, 1'b0, 8'h00);
    #2 rst = 1'b0;
    #1;
    check_output("async_rst_halted", 32'(halted), 32'h0);
    check_output("async_rst_imem_pc", 32'(imem_pc), 32'h00);
    check_output("async_rst_fetch_count", 32'(fetch_count), 32'h0);
    check_output("async_rst_if_pc", 32'(if_pc), 32'h00);

    @(negedge clk);
    rst = 1'b1;
    step();
    check_output("reboot_if_valid", 32'(if_valid), 32'h0);
    step();
    check_output("reboot_if_instruct", if_instruct, 32'h1111_1111);
    check_output("reboot_fetch_count", 32'(fetch_count), 32'd1);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
